// File: rtl/hazard_controller_pkg.sv
// Shared RV32I decode constants and hazard-controller types.
package hazard_controller_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } usage_t;

endpackage

// File: rtl/hazard_controller_operand_usage_decoder.sv
// Opcode -> register operand usage; purely combinational, shared with forwarding.
module hazard_controller_operand_usage_decoder
  import hazard_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output usage_t     usage
);

  always_comb begin
    usage = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        usage.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        usage.uses_rs1  = 1'b1;
        usage.writes_rd = 1'b1;
      end
      OPC_OP: begin
        usage.uses_rs1  = 1'b1;
        usage.uses_rs2  = 1'b1;
        usage.writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        usage.uses_rs1 = 1'b1;
        usage.uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: register scoreboard, RAW/WAW stall, post-branch flush.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter bit          WB_BYPASS    = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_id,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rs_1_num,
  input  logic [4:0]       i_rs_2_num,
  input  logic [4:0]       i_rd_num,
  input  logic             i_b_taken,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd_num,
  output logic             o_issue,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic [31:0]      o_busy_regs,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  usage_t      usage;
  state_t      state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] busy_q, busy_d, wb_mask, busy_eff;
  logic        active_q;
  logic        hazard, issue, stall, flush;

  hazard_controller_operand_usage_decoder u_usage (
    .opcode (i_opcode),
    .usage  (usage)
  );

  assign wb_mask  = i_wb_valid ? (32'd1 << i_wb_rd_num) : '0;
  assign busy_eff = WB_BYPASS ? (busy_q & ~wb_mask) : busy_q;

  // busy_q[0] is held at 0, so x0 operands never hazard.
  assign hazard = i_valid_id &
                  ((usage.uses_rs1  & busy_eff[i_rs_1_num]) |
                   (usage.uses_rs2  & busy_eff[i_rs_2_num]) |
                   (usage.writes_rd & busy_eff[i_rd_num]));

  // RUN and STALL share one evaluation: stall tracks the live hazard, so the
  // instruction issues in the very cycle the hazard clears. Everything is held
  // quiet until the first edge after reset release (active_q).
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    issue   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    if (active_q) begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          stall = hazard;
          issue = i_valid_id & ~hazard;
          if (hazard) begin
            state_d = ST_STALL;
          end else if (issue && i_b_taken) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush  = 1'b1;
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // A new writer issuing in the same cycle as an older writeback keeps the bit set.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (issue && usage.writes_rd) begin
      busy_d[i_rd_num] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      busy_q      <= '0;
      active_q    <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      busy_q   <= busy_d;
      active_q <= 1'b1;
      if (stall && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + 1'b1;
      end
    end
  end

  assign o_issue     = issue;
  assign o_stall_if  = stall;
  assign o_stall_id  = stall;
  assign o_bubble_ex = stall | flush;
  assign o_flush_id  = flush;
  assign o_busy_regs = busy_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: two instances (bypass/flush=2 and no-bypass/flush=1).
module tb_hazard_controller;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       bt;
    logic       wbv;
    logic [4:0] wbrd;
  } stim_t;

  typedef struct {
    string       tag;
    bit          sel;
    logic [4:0]  flags;
    logic [31:0] busy;
    logic [15:0] cnt;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t sa  = '0;
  stim_t sb  = '0;

  logic        a_issue, a_stall_if, a_stall_id, a_bubble, a_flush;
  logic [31:0] a_busy;
  logic [15:0] a_cnt;
  logic        b_issue, b_stall_if, b_stall_id, b_bubble, b_flush;
  logic [31:0] b_busy;
  logic [15:0] b_cnt;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  hazard_controller #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_valid_id(sa.valid), .i_opcode(sa.opc),
    .i_rs_1_num(sa.rs1), .i_rs_2_num(sa.rs2), .i_rd_num(sa.rd),
    .i_b_taken(sa.bt), .i_wb_valid(sa.wbv), .i_wb_rd_num(sa.wbrd),
    .o_issue(a_issue), .o_stall_if(a_stall_if), .o_stall_id(a_stall_id),
    .o_bubble_ex(a_bubble), .o_flush_id(a_flush),
    .o_busy_regs(a_busy), .o_stall_cnt(a_cnt)
  );

  hazard_controller #(.FLUSH_CYCLES(1), .WB_BYPASS(1'b0), .CNT_W(16)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_valid_id(sb.valid), .i_opcode(sb.opc),
    .i_rs_1_num(sb.rs1), .i_rs_2_num(sb.rs2), .i_rd_num(sb.rd),
    .i_b_taken(sb.bt), .i_wb_valid(sb.wbv), .i_wb_rd_num(sb.wbrd),
    .o_issue(b_issue), .o_stall_if(b_stall_if), .o_stall_id(b_stall_id),
    .o_bubble_ex(b_bubble), .o_flush_id(b_flush),
    .o_busy_regs(b_busy), .o_stall_cnt(b_cnt)
  );

  function automatic stim_t mk(input logic v, input logic [6:0] opc,
                               input logic [4:0] rs1, rs2, rd,
                               input logic bt, wbv, input logic [4:0] wbrd);
    stim_t s;
    s.valid = v; s.opc = opc; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.bt = bt; s.wbv = wbv; s.wbrd = wbrd;
    return s;
  endfunction

  // flags = {issue, stall_if, stall_id, bubble_ex, flush_id}
  task automatic expect_out(input string tag, input bit sel, input logic ei, es, ef,
                            input logic [31:0] eb, input logic [15:0] ec);
    exp_t e;
    e.tag = tag; e.sel = sel;
    e.flags = {ei, es, es, es | ef, ef};
    e.busy = eb; e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [4:0]  of;
    logic [31:0] ob;
    logic [15:0] oc;
    if (q.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = q.pop_front();
    if (e.sel) begin
      of = {b_issue, b_stall_if, b_stall_id, b_bubble, b_flush}; ob = b_busy; oc = b_cnt;
    end else begin
      of = {a_issue, a_stall_if, a_stall_id, a_bubble, a_flush}; ob = a_busy; oc = a_cnt;
    end
    compared++;
    assert (of === e.flags) else begin
      mismatched++;
      $error("FAIL %s.flags observed=%b expected=%b", e.tag, of, e.flags);
    end
    compared++;
    assert (ob === e.busy) else begin
      mismatched++;
      $error("FAIL %s.busy observed=%h expected=%h", e.tag, ob, e.busy);
    end
    compared++;
    assert (oc === e.cnt) else begin
      mismatched++;
      $error("FAIL %s.cnt observed=%0d expected=%0d", e.tag, oc, e.cnt);
    end
  endtask

  task automatic step(input string tag, input bit sel, input stim_t s,
                      input logic ei, es, ef, input logic [31:0] eb, input logic [15:0] ec);
    @(negedge clk);
    if (sel) begin sb = s; sa = '0; end
    else     begin sa = s; sb = '0; end
    expect_out(tag, sel, ei, es, ef, eb, ec);
    #2;
    check();
  endtask

  // Reset pulse with a valid writer in decode: nothing may issue while in reset
  // or in the first cycle after release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    sa = mk(1, OP, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    sb = sa;
    expect_out({tag, "_in_rst_a"}, 0, 0, 0, 0, 32'h0, 16'd0);
    expect_out({tag, "_in_rst_b"}, 1, 0, 0, 0, 32'h0, 16'd0);
    #2; check(); check();
    @(negedge clk);
    rst = 1'b0;
    expect_out({tag, "_post_rel_a"}, 0, 0, 0, 0, 32'h0, 16'd0);
    expect_out({tag, "_post_rel_b"}, 1, 0, 0, 0, 32'h0, 16'd0);
    #2; check(); check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst0");

    // RAW stall without write-through: 4 stalls, issue after writeback
    step("b_add_x5",   1, mk(1, OP, 5'd1, 5'd2, 5'd5, 0, 0, 0), 1, 0, 0, 32'h0,  16'd0);
    step("b_raw_s1",   1, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd0);
    step("b_raw_s2",   1, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd1);
    step("b_raw_s3",   1, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd2);
    step("b_raw_wb",   1, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 1, 5'd5), 0, 1, 0, 32'h20, 16'd3);
    step("b_raw_iss",  1, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 1, 0, 0, 32'h0,  16'd4);
    step("b_idle",     1, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 0, 0), 0, 0, 0, 32'h40, 16'd4);

    // RAW stall with write-through: 3 stalls, issue in the writeback cycle
    step("a_add_x5",   0, mk(1, OP, 5'd1, 5'd2, 5'd5, 0, 0, 0), 1, 0, 0, 32'h0,  16'd0);
    step("a_raw_s1",   0, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd0);
    step("a_raw_s2",   0, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd1);
    step("a_raw_s3",   0, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 0, 0), 0, 1, 0, 32'h20, 16'd2);
    step("a_raw_wb",   0, mk(1, OP, 5'd5, 5'd1, 5'd6, 0, 1, 5'd5), 1, 0, 0, 32'h20, 16'd3);
    step("a_idle1",    0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 0, 0), 0, 0, 0, 32'h40, 16'd3);
    step("a_wb_x6",    0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 1, 5'd6), 0, 0, 0, 32'h40, 16'd3);

    // Taken branch: two flush cycles, valid decode ignored, then issue
    step("a_beq",      0, mk(1, BRANCH, 5'd1, 5'd2, 5'd0, 1, 0, 0), 1, 0, 0, 32'h0, 16'd3);
    step("a_flush1",   0, mk(1, OP, 5'd1, 5'd2, 5'd8, 0, 0, 0), 0, 0, 1, 32'h0,   16'd3);
    step("a_flush2",   0, mk(1, OP, 5'd1, 5'd2, 5'd8, 0, 0, 0), 0, 0, 1, 32'h0,   16'd3);
    step("a_post_fl",  0, mk(1, OP, 5'd1, 5'd2, 5'd8, 0, 0, 0), 1, 0, 0, 32'h0,   16'd3);
    step("a_wb_x8",    0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 1, 5'd8), 0, 0, 0, 32'h100, 16'd3);

    // x0 never tracked
    step("a_addi_x0",  0, mk(1, OP_IMM, 5'd0, 5'd0, 5'd0, 0, 0, 0), 1, 0, 0, 32'h0, 16'd3);
    step("a_add_x7",   0, mk(1, OP, 5'd0, 5'd0, 5'd7, 0, 0, 0), 1, 0, 0, 32'h0,     16'd3);
    step("a_wb_x7",    0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 1, 5'd7), 0, 0, 0, 32'h80, 16'd3);

    // New x9 writer alongside an older x9 writeback: set wins
    step("a_lw_x9",    0, mk(1, LOAD, 5'd1, 5'd0, 5'd9, 0, 0, 0), 1, 0, 0, 32'h0,     16'd3);
    step("a_lw_x9_wb", 0, mk(1, LOAD, 5'd2, 5'd0, 5'd9, 0, 1, 5'd9), 1, 0, 0, 32'h200, 16'd3);
    step("a_use_x9",   0, mk(1, OP, 5'd9, 5'd1, 5'd10, 0, 0, 0), 0, 1, 0, 32'h200, 16'd3);
    step("a_use_x9wb", 0, mk(1, OP, 5'd9, 5'd1, 5'd10, 0, 1, 5'd9), 1, 0, 0, 32'h200, 16'd4);
    step("a_wb_x10",   0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 1, 5'd10), 0, 0, 0, 32'h400, 16'd4);

    // Reset in the middle of a flush with x5/x9 pending
    step("a_addi_x5",  0, mk(1, OP_IMM, 5'd0, 5'd0, 5'd5, 0, 0, 0), 1, 0, 0, 32'h0,  16'd4);
    step("a_addi_x9",  0, mk(1, OP_IMM, 5'd0, 5'd0, 5'd9, 0, 0, 0), 1, 0, 0, 32'h20, 16'd4);
    step("a_jal",      0, mk(1, JAL, 5'd0, 5'd0, 5'd0, 1, 0, 0), 1, 0, 0, 32'h220,   16'd4);
    step("a_jal_fl1",  0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 0, 0), 0, 0, 1, 32'h220,   16'd4);
    do_reset("rst_mid_flush");
    step("a_dep_post", 0, mk(1, OP, 5'd5, 5'd9, 5'd11, 0, 0, 0), 1, 0, 0, 32'h0, 16'd0);
    step("a_idle_end", 0, mk(0, OP, 5'd0, 5'd0, 5'd0, 0, 0, 0), 0, 0, 0, 32'h800, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
